// File: rtl/sprite_sram_writer.sv
// Sprite loader: takes a streamed 24-bit image, packs pixels to RGB565 and
// writes them to the shared SRAM at base+index, flagging per-pixel opacity.
module sprite_sram_writer #(
    parameter int          SRAM_ADDR_W = 20,
    parameter int          SRAM_DATA_W = 16,
    parameter int          SPRITE_SIZE = 32,
    parameter int          COOR_W      = $clog2(SPRITE_SIZE),
    parameter int          OBJ_ID_W    = 2,
    parameter logic [23:0] KEY_COLOR   = 24'hFF00FF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [OBJ_ID_W-1:0]    i_obj_id,
    input  logic [SRAM_ADDR_W-1:0] i_base_addr,
    input  logic [23:0]            i_pix_data,
    input  logic                   i_pix_valid,
    output logic                   o_pix_ready,
    output logic                   o_sram_writing,
    output logic [SRAM_ADDR_W-1:0] o_sram_addr,
    output logic [SRAM_DATA_W-1:0] o_sram_data,
    output logic [2*COOR_W-1:0]    o_pixel_counter,
    output logic [OBJ_ID_W-1:0]    o_object_id,
    output logic                   o_pixel_opacity,
    output logic                   o_pixel_opacity_valid,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int               CNT_W = 2 * COOR_W;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(SPRITE_SIZE * SPRITE_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [OBJ_ID_W-1:0]    obj_id_q, obj_id_d;
    logic [SRAM_ADDR_W-1:0] base_q, base_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [SRAM_DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]       pix_cnt_q, pix_cnt_d;
    logic                   opacity_q, opacity_d;
    logic                   accept;
    logic [15:0]            rgb565;

    assign accept = (state_q == S_RECV) && i_pix_valid;
    assign rgb565 = {i_pix_data[23:19], i_pix_data[15:10], i_pix_data[7:3]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_RECV;
            S_RECV:  if (i_pix_valid) state_d = S_WRITE;
            S_WRITE: state_d = (cnt_q == LAST) ? S_DONE : S_RECV;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Write-cycle payload is captured on the accept edge so WRITE drives it
    // straight from flops; it then holds until the next accepted pixel.
    always_comb begin
        cnt_d     = cnt_q;
        obj_id_d  = obj_id_q;
        base_d    = base_q;
        addr_d    = addr_q;
        data_d    = data_q;
        pix_cnt_d = pix_cnt_q;
        opacity_d = opacity_q;
        if (state_q == S_IDLE && i_start) begin
            cnt_d    = '0;
            obj_id_d = i_obj_id;
            base_d   = i_base_addr;
        end
        if (accept) begin
            addr_d    = base_q + SRAM_ADDR_W'(cnt_q);
            data_d    = SRAM_DATA_W'(rgb565);
            pix_cnt_d = cnt_q;
            opacity_d = (i_pix_data != KEY_COLOR);
        end
        if (state_q == S_WRITE && cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            obj_id_q  <= '0;
            base_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            pix_cnt_q <= '0;
            opacity_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            obj_id_q  <= obj_id_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            pix_cnt_q <= pix_cnt_d;
            opacity_q <= opacity_d;
        end
    end

    always_comb begin
        o_pix_ready           = (state_q == S_RECV);
        o_sram_writing        = (state_q == S_WRITE);
        o_pixel_opacity_valid = (state_q == S_WRITE);
        o_busy                = (state_q != S_IDLE);
        o_done                = (state_q == S_DONE);
        o_sram_addr           = addr_q;
        o_sram_data           = data_q;
        o_pixel_counter       = pix_cnt_q;
        o_object_id           = obj_id_q;
        o_pixel_opacity       = opacity_q;
    end

endmodule

// File: tb/tb_sprite_sram_writer.sv
// Directed bench for sprite_sram_writer: reset, full load with colour key and
// gaps, address wrap with ignored mid-load start, and reset abort/reload.
module tb_sprite_sram_writer;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [1:0]  i_obj_id = '0;
    logic [19:0] i_base_addr = '0;
    logic [23:0] i_pix_data = '0;
    logic        i_pix_valid = 1'b0;
    logic        o_pix_ready, o_sram_writing, o_pixel_opacity, o_pixel_opacity_valid;
    logic        o_busy, o_done;
    logic [19:0] o_sram_addr;
    logic [15:0] o_sram_data;
    logic [9:0]  o_pixel_counter;
    logic [1:0]  o_object_id;

    int total = 0;
    int bad = 0;
    int writes_seen = 0;
    int writes_exp = 0;
    logic        prev_wr = 1'b0;
    logic [19:0] exp_base;
    logic [1:0]  exp_id;
    int          exp_idx;

    sprite_sram_writer #(.SRAM_ADDR_W(20), .SRAM_DATA_W(16), .SPRITE_SIZE(32),
                         .OBJ_ID_W(2), .KEY_COLOR(24'hFF00FF)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_obj_id(i_obj_id),
        .i_base_addr(i_base_addr), .i_pix_data(i_pix_data), .i_pix_valid(i_pix_valid),
        .o_pix_ready(o_pix_ready), .o_sram_writing(o_sram_writing),
        .o_sram_addr(o_sram_addr), .o_sram_data(o_sram_data),
        .o_pixel_counter(o_pixel_counter), .o_object_id(o_object_id),
        .o_pixel_opacity(o_pixel_opacity), .o_pixel_opacity_valid(o_pixel_opacity_valid),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write strobe must never last two cycles; count every write cycle.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (prev_wr) check("no_back_to_back_write", {31'd0, o_sram_writing}, 32'd0);
            if (o_sram_writing) writes_seen++;
        end
        prev_wr = o_sram_writing && i_rst_n;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {o_pix_ready, o_sram_writing, o_pixel_opacity,
               o_pixel_opacity_valid, o_busy, o_done, o_object_id}, 32'd0);
        check({tag, "_addr"}, {12'd0, o_sram_addr}, 32'd0);
        check({tag, "_data_cnt"}, {6'd0, o_pixel_counter, o_sram_data}, 32'd0);
    endtask

    task automatic start_load(input logic [1:0] id, input logic [19:0] base);
        i_start = 1'b1; i_obj_id = id; i_base_addr = base;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_obj_id = '0; i_base_addr = '0;
        exp_base = base; exp_id = id; exp_idx = 0;
        check("start_ready", {30'd0, o_pix_ready, o_busy}, 32'd3);
    endtask

    // Called #1 after an edge with the DUT in RECV.
    task automatic push(input logic [23:0] pix, input int gap);
        logic [19:0] ea;
        logic [15:0] ed;
        int n;
        for (int g = 0; g < gap; g++) begin
            i_pix_valid = 1'b0;
            @(posedge i_clk); #1;
            check("gap_idle", {30'd0, o_pix_ready, o_sram_writing}, 32'd2);
        end
        i_pix_valid = 1'b1; i_pix_data = pix;
        n = 0;
        while (!o_pix_ready && n < 20) begin
            @(posedge i_clk); #1; n++;
        end
        if (!o_pix_ready) begin
            $error("FAIL ready_timeout observed=0 expected=1");
            bad++;
            $fatal(1, "ready never asserted");
        end
        @(posedge i_clk); #1;
        i_pix_valid = 1'b0;
        writes_exp++;
        ea = exp_base + 20'(exp_idx);
        ed = {pix[23:19], pix[15:10], pix[7:3]};
        check("wr_strobe", {29'd0, o_sram_writing, o_pixel_opacity_valid, o_pix_ready}, 32'd6);
        check("wr_addr", {12'd0, o_sram_addr}, {12'd0, ea});
        check("wr_data", {16'd0, o_sram_data}, {16'd0, ed});
        check("wr_opacity", {31'd0, o_pixel_opacity}, {31'd0, pix != 24'hFF00FF});
        check("wr_counter", {22'd0, o_pixel_counter}, 32'(exp_idx));
        check("wr_obj_id", {30'd0, o_object_id}, {30'd0, exp_id});
        @(posedge i_clk); #1;
        check("wr_single_cycle", {31'd0, o_sram_writing}, 32'd0);
        check("hold_addr", {12'd0, o_sram_addr}, {12'd0, ea});
        exp_idx++;
    endtask

    initial begin
        logic [23:0] px;

        // Reset with random inputs
        for (int c = 0; c < 4; c++) begin
            i_start = 1'($urandom); i_pix_valid = 1'($urandom);
            i_pix_data = 24'($urandom); i_obj_id = 2'($urandom); i_base_addr = 20'($urandom);
            @(posedge i_clk); #1;
            check_all_zero("reset");
        end
        i_start = 1'b0; i_pix_valid = 1'b0;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        check_all_zero("idle_after_reset");

        // Full load with colour-key pixels and random gaps
        start_load(2'd2, 20'h01000);
        for (int k = 0; k < 1024; k++) begin
            px = 24'(k);
            if (k == 5) px = 24'hFF00FF;
            if (k == 6) px = 24'hFF00FE;
            push(px, (k % 7 == 3) ? int'($urandom_range(0, 3)) : 0);
            if (k == 5) check("key_transparent", {31'd0, o_pixel_opacity}, 32'd0);
            if (k == 6) check("near_key", {15'd0, o_pixel_opacity, o_sram_data}, 32'h1F81F);
            if (k < 1023) check("not_done_yet", {31'd0, o_done}, 32'd0);
        end
        check("done_pulse", {29'd0, o_done, o_busy, o_pix_ready}, 32'd6);
        check("last_addr", {12'd0, o_sram_addr}, 32'h013FF);
        @(posedge i_clk); #1;
        check("done_to_idle", {29'd0, o_done, o_busy, o_pix_ready}, 32'd0);
        check("id_held", {30'd0, o_object_id}, 32'd2);
        check("full_write_count", 32'(writes_seen), 32'd1024);

        // Address wrap, mid-load start ignored, then reset abort at pixel 500
        start_load(2'd1, 20'hFFFF0);
        for (int k = 0; k < 500; k++) begin
            if (k == 8) begin
                i_start = 1'b1; i_obj_id = 2'd3; i_base_addr = 20'h55555;
            end
            push(24'hA0B0C0 ^ 24'(k), 0);
            i_start = 1'b0;
            if (k == 16) check("wrap_addr_zero", {12'd0, o_sram_addr}, 32'd0);
            if (k == 15) check("pre_wrap_addr", {12'd0, o_sram_addr}, 32'hFFFFF);
        end
        check("mid_start_ignored_id", {30'd0, o_object_id}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        check_all_zero("abort_reset");
        @(posedge i_clk); #1;
        check_all_zero("abort_reset_next");
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Reload starts from counter 0
        start_load(2'd3, 20'h00200);
        push(24'h123456, 1);
        check("reload_counter0", {22'd0, o_pixel_counter}, 32'd0);
        check("total_write_count", 32'(writes_seen), 32'(writes_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $error("FAIL global_timeout observed=running expected=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
